// File: rtl/partition_engine.sv
// partition_engine: Lomuto partition of array[lo..hi] around pivot array[hi], one element per cycle.
// Ascending puts keys <= pivot on the left; descending puts keys >= pivot on the left.
module partition_engine #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IDX_W-1:0]          lo_ind,
    input  logic [IDX_W-1:0]          hi_ind,
    input  logic                      descending,
    input  logic [DATA_W*DEPTH-1:0]   array_in,
    output logic                      ready,
    output logic [DATA_W*DEPTH-1:0]   array_out,
    output logic [IDX_W-1:0]          pivot_ind_out,
    output logic                      part_valid,
    output logic                      err
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] arr [DEPTH];
    logic [DATA_W-1:0] fin [DEPTH];
    logic [DATA_W*DEPTH-1:0] fin_flat;
    logic [IDX_W-1:0] i, j, hi;
    logic dir, range_ok, take, accept, last;
    assign ready    = state == IDLE;
    assign accept   = ready && start;
    assign range_ok = hi_ind >= lo_ind && int'(hi_ind) < DEPTH;
    assign last     = j == hi;
    assign take     = dir ? arr[j] >= arr[hi] : arr[j] <= arr[hi];
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = accept && range_ok ? SCAN : IDLE;
        else               state_nx = last ? IDLE : SCAN;
    end
    // Final pivot swap, applied combinationally so completion can publish it directly.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) fin[k] = arr[k];
        fin[i]  = arr[hi];
        fin[hi] = arr[i];
        fin_flat = '0;
        for (int k = 0; k < DEPTH; k++) fin_flat[(DEPTH-k)*DATA_W-1 -: DATA_W] = fin[k];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) arr[k] <= '0;
            i             <= '0;
            j             <= '0;
            hi            <= '0;
            dir           <= 1'b0;
            array_out     <= '0;
            pivot_ind_out <= '0;
            part_valid    <= 1'b0;
            err           <= 1'b0;
        end else begin
            part_valid <= 1'b0;
            if (accept && range_ok) begin
                for (int k = 0; k < DEPTH; k++) arr[k] <= array_in[(DEPTH-k)*DATA_W-1 -: DATA_W];
                i   <= lo_ind;
                j   <= lo_ind;
                hi  <= hi_ind;
                dir <= descending;
            end else if (accept) begin
                array_out     <= array_in;
                pivot_ind_out <= lo_ind;
                err           <= 1'b1;
                part_valid    <= 1'b1;
            end else if (state == SCAN && !last) begin
                if (take) begin
                    arr[i] <= arr[j];
                    arr[j] <= arr[i];
                    i      <= i + 1'b1;
                end
                j <= j + 1'b1;
            end else if (state == SCAN) begin
                for (int k = 0; k < DEPTH; k++) arr[k] <= fin[k];
                array_out     <= fin_flat;
                pivot_ind_out <= i;
                err           <= 1'b0;
                part_valid    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_partition_engine.sv
// tb_partition_engine: directed vectors with hand-computed partitions, latencies and error cases.
module tb_partition_engine;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  lo_ind = '0;
    logic [2:0]  hi_ind = '0;
    logic        descending = 1'b0;
    logic [63:0] array_in = '0;
    logic        ready;
    logic [63:0] array_out;
    logic [2:0]  pivot_ind_out;
    logic        part_valid;
    logic        err;
    int tests = 0;
    int fails = 0;

    partition_engine dut (
        .clock(clock), .reset(reset), .start(start), .lo_ind(lo_ind), .hi_ind(hi_ind),
        .descending(descending), .array_in(array_in), .ready(ready), .array_out(array_out),
        .pivot_ind_out(pivot_ind_out), .part_valid(part_valid), .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge where part_valid is seen (or bound expired).
    task automatic run(input string tag, input logic [63:0] a, input int lo, input int hi,
                       input logic desc, input logic [63:0] exp_a, input int exp_piv,
                       input int exp_lat, input logic exp_err, input logic poke);
        int lat;
        check({tag, " ready_idle"}, 64'(ready), 64'd1);
        array_in   = a;
        lo_ind     = 3'(lo);
        hi_ind     = 3'(hi);
        descending = desc;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat   = 0;
        if (exp_lat > 0) begin
            check({tag, " ready_busy"}, 64'(ready), 64'd0);
            check({tag, " pulse_low"}, 64'(part_valid), 64'd0);
        end
        while (!part_valid && lat < 20) begin
            start = poke && lat == 2;
            if (start) begin
                array_in = '1;
                lo_ind   = 3'd1;
                hi_ind   = 3'd2;
            end
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " array"}, array_out, exp_a);
        check({tag, " pivot"}, 64'(pivot_ind_out), 64'(exp_piv));
        check({tag, " err"}, 64'(err), 64'(exp_err));
        check({tag, " ready_done"}, 64'(ready), 64'd1);
    endtask

    localparam logic [63:0] A = 64'h0503080109020704;

    initial begin
        logic seen;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst array", array_out, 64'h0);
        check("rst pivot", 64'(pivot_ind_out), 64'd0);
        check("rst valid", 64'(part_valid), 64'd0);
        check("rst err", 64'(err), 64'd0);
        check("rst ready", 64'(ready), 64'd1);
        // Runs are chained with no idle gap, so each start lands in the previous completion cycle.
        run("asc_full",  A, 0, 7, 1'b0, 64'h0301020409080705, 3, 8, 1'b0, 1'b0);
        run("desc_full", A, 0, 7, 1'b1, 64'h0508090704020103, 4, 8, 1'b0, 1'b0);
        run("asc_sub",   A, 2, 5, 1'b0, 64'h0503010209080704, 3, 4, 1'b0, 1'b0);
        run("single",    A, 6, 6, 1'b0, A, 6, 1, 1'b0, 1'b0);
        run("bad_range", A, 5, 2, 1'b0, A, 5, 0, 1'b1, 1'b0);
        @(negedge clock);
        check("err pulse", 64'(part_valid), 64'd0);
        check("err held", 64'(err), 64'd1);
        run("all_equal", 64'h0707070707070707, 0, 7, 1'b0, 64'h0707070707070707, 7, 8, 1'b0, 1'b1);
        @(negedge clock);
        array_in = A; lo_ind = 3'd0; hi_ind = 3'd7; descending = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort array", array_out, 64'h0);
        check("abort pivot", 64'(pivot_ind_out), 64'd0);
        check("abort err", 64'(err), 64'd0);
        check("abort ready", 64'(ready), 64'd1);
        seen = 1'b0;
        repeat (10) begin
            seen |= part_valid;
            @(negedge clock);
        end
        check("abort no_valid", 64'(seen), 64'd0);
        run("after_abort", A, 0, 7, 1'b0, 64'h0301020409080705, 3, 8, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
